// File: rtl/memory_verify.sv
// memory_verify: reads back every blanked SRAM word (0..LAST_ADDR) and checks
// it against the fill pattern {8{A[0]}, 16'h5533, A[7:0]}. It reports pass/fail,
// a saturating error count and the first failing address/data.
// Optional build macro MEMVERIFY_STOP_ON_ERROR_EN: stop at the first mismatch.
module memory_verify #(
  parameter int ADDR_WIDTH   = 18,
  parameter int LAST_ADDR    = 262141,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pause,
  input  logic [31:0]           data_read,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] error_count,
  output logic [ADDR_WIDTH-1:0] first_error_address,
  output logic [31:0]           first_error_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   counter_q, counter_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic                    rden_q, rden_d;
  logic [ADDR_WIDTH-1:0]   error_count_q, error_count_d;
  logic [ADDR_WIDTH-1:0]   first_addr_q, first_addr_d;
  logic [31:0]             first_data_q, first_data_d;

  // Tag pipe: entry 0 is loaded from the registered strobe/address the SRAM
  // actually sees, so the last entry lines up with data_read.
  logic                    pipe_valid_q [READ_LATENCY];
  logic                    pipe_valid_d [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_tag_q   [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_tag_d   [READ_LATENCY];
  logic                    pipe_flush;

  logic                    out_valid;
  logic [ADDR_WIDTH-1:0]   out_tag;
  logic [31:0]             expected_word;
  logic                    mismatch;
  logic                    drain_busy;

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_d[gi] = rden_q & ~pipe_flush;
        assign pipe_tag_d[gi]   = address_q;
      end else begin : g_body
        assign pipe_valid_d[gi] = pipe_valid_q[gi-1] & ~pipe_flush;
        assign pipe_tag_d[gi]   = pipe_tag_q[gi-1];
      end
    end
  endgenerate

  assign out_valid     = pipe_valid_q[READ_LATENCY-1];
  assign out_tag       = pipe_tag_q[READ_LATENCY-1];
  assign expected_word = {{8{out_tag[0]}}, 16'h5533, out_tag[7:0]};
  assign mismatch      = out_valid && (data_read != expected_word);

  // Reads still outstanding after this edge (the output entry is consumed now).
  always_comb begin
    drain_busy = rden_q;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      drain_busy = drain_busy | pipe_valid_q[i];
    end
  end

  // Next-state, issue and compare logic.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    address_d     = address_q;
    rden_d        = 1'b0;
    error_count_d = error_count_q;
    first_addr_d  = first_addr_q;
    first_data_d  = first_data_q;
    pipe_flush    = 1'b0;

    // A result landing on the same edge as the move to DONE is still counted.
    if (mismatch) begin
      if (error_count_q != ALL_ONES) begin
        error_count_d = error_count_q + 1'b1;
      end
      if (error_count_q == '0) begin
        first_addr_d = out_tag;
        first_data_d = data_read;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_ISSUE;
          counter_d = '0;
        end
      end
      S_ISSUE: begin
        if (!pause) begin
          address_d = counter_q;
          rden_d    = 1'b1;
          if (counter_q == LAST) begin
            state_d = S_DRAIN;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!drain_busy) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase

`ifdef MEMVERIFY_STOP_ON_ERROR_EN
    // First mismatch ends the run; reads still in flight are dropped.
    if (mismatch) begin
      state_d    = S_DONE;
      rden_d     = 1'b0;
      pipe_flush = 1'b1;
    end
`endif
  end

  // State registers; reset or enable low returns everything to idle/zero.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q       <= S_IDLE;
      counter_q     <= '0;
      address_q     <= '0;
      rden_q        <= 1'b0;
      error_count_q <= '0;
      first_addr_q  <= '0;
      first_data_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_tag_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      address_q     <= address_d;
      rden_q        <= rden_d;
      error_count_q <= error_count_d;
      first_addr_q  <= first_addr_d;
      first_data_q  <= first_data_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_tag_q[i]   <= pipe_tag_d[i];
      end
    end
  end

  assign rden                = rden_q;
  assign address             = address_q;
  assign done                = (state_q == S_DONE);
  assign pass                = (state_q == S_DONE) && (error_count_q == '0);
  assign error_count         = error_count_q;
  assign first_error_address = first_addr_q;
  assign first_error_data    = first_data_q;

endmodule

// File: tb/tb_memory_verify.sv
// Testbench for memory_verify: SRAM read model, table of verify runs with a
// scoreboard queue of expected run results, read-order monitor, and an
// abort/rescan sequence. Uses a reduced LAST_ADDR to keep runs short.
module tb_memory_verify;
  localparam int AW   = 18;
  localparam int LAST = 1100;
  localparam int RL   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          pause = 1'b0;
  logic [31:0]   data_read;
  logic          rden;
  logic [AW-1:0] address;
  logic          done;
  logic          pass;
  logic [AW-1:0] error_count;
  logic [AW-1:0] first_error_address;
  logic [31:0]   first_error_data;

  memory_verify #(.ADDR_WIDTH(AW), .LAST_ADDR(LAST), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause),
    .data_read(data_read), .rden(rden), .address(address), .done(done),
    .pass(pass), .error_count(error_count),
    .first_error_address(first_error_address),
    .first_error_data(first_error_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    logic [AW-1:0] av;
    av = a[AW-1:0];
    return {{8{av[0]}}, 16'h5533, av[7:0]};
  endfunction

  // SRAM model: strobe sampled at an edge, data valid RL cycles after rden rose.
  logic [31:0]   mem [0:LAST];
  logic          m_v [RL] = '{default: 1'b0};
  logic [AW-1:0] m_a [RL];
  always @(posedge clk) begin
    m_v[0] <= rden;
    m_a[0] <= address;
    for (int i = 1; i < RL; i++) begin
      m_v[i] <= m_v[i-1];
      m_a[i] <= m_a[i-1];
    end
  end
  assign data_read = (m_v[RL-1] === 1'b1) ? mem[m_a[RL-1]] : 32'hDEADBEEF;

  // Read-order monitor: every issued address must be the next one in sequence.
  bit mon_en = 1'b0;
  int next_addr = 0;
  int rden_cycles = 0;
  always @(negedge clk) begin
    if (mon_en && rden === 1'b1) begin
      rden_cycles++;
      chk("read_order", 64'(address), 64'(next_addr));
      next_addr++;
    end
  end

  // Random pause generator.
  int pause_pct = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pause = ($urandom_range(0, 99) < pause_pct);
    end
  end

  typedef struct {
    int          nc;
    int          c0, c1, c2;
    int          pause_pct;
    bit          exp_pass;
    int          exp_cnt;
    int          exp_faddr;
    logic [31:0] exp_fdata;
  } vec_t;

  vec_t vecs[5];
  vec_t sb_q[$];

  task automatic load_mem(input vec_t tv);
    for (int a = 0; a <= LAST; a++) mem[a] = pat(a);
    if (tv.nc > 0) mem[tv.c0] = 32'h0;
    if (tv.nc > 1) mem[tv.c1] = 32'h0;
    if (tv.nc > 2) mem[tv.c2] = 32'h0;
  endtask

  task automatic wait_done(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    while (lat < 20000) begin
      @(posedge clk);
      lat++;
      #1;
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_rden"}, 64'(rden), 64'd0);
    chk({tag, "_address"}, 64'(address), 64'd0);
    chk({tag, "_error_count"}, 64'(error_count), 64'd0);
    chk({tag, "_first_addr"}, 64'(first_error_address), 64'd0);
    chk({tag, "_first_data"}, 64'(first_error_data), 64'd0);
  endtask

  task automatic run_vec(input vec_t tv, input int idx);
    vec_t e;
    int   lat;
    bit   to;
    int   rc;
    bit   stop_mode;
    e = tv;
    stop_mode = 1'b0;
`ifdef MEMVERIFY_STOP_ON_ERROR_EN
    if (e.nc > 0) begin
      e.exp_cnt = 1;
      stop_mode = 1'b1;
    end
`endif
    load_mem(tv);
    sb_q.push_back(e);
    pause_pct   = tv.pause_pct;
    next_addr   = 0;
    rden_cycles = 0;
    mon_en      = 1'b1;
    enable      = 1'b1;
    @(posedge clk);
    wait_done(lat, to);
    chk("done_timeout", 64'(to), 64'd0);
    e = sb_q.pop_front();
    chk("pass", 64'(pass), 64'(e.exp_pass));
    chk("error_count", 64'(error_count), 64'(e.exp_cnt));
    chk("first_error_address", 64'(first_error_address), 64'(e.exp_faddr));
    chk("first_error_data", 64'(first_error_data), 64'(e.exp_fdata));
    if (!stop_mode) begin
      chk("rden_cycles", 64'(rden_cycles), 64'(LAST + 1));
      if (tv.pause_pct == 0) chk("done_latency", 64'(lat), 64'(LAST + RL + 2));
    end
    // done must hold and no further reads may issue.
    rc = rden_cycles;
    repeat (4) @(posedge clk);
    #1;
    chk("done_hold", 64'(done), 64'd1);
    chk("no_rden_after_done", 64'(rden_cycles), 64'(rc));
    mon_en    = 1'b0;
    pause_pct = 0;
    enable    = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("disable");
    $display("run %0d: corrupt=%0d pause=%0d%% lat=%0d pass=%0d errors=%0d first=%0h/%08h reads=%0d",
             idx, tv.nc, tv.pause_pct, lat, pass, error_count, first_error_address,
             first_error_data, rden_cycles);
  endtask

  initial begin
    vec_t clean;
    int   lat;
    bit   to;
    int   guard;

    // Reset dominates enable.
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    enable = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{0, 0, 0, 0, 0, 1'b1, 0, 0, 32'h0};
    vecs[1] = '{1, 'h100, 0, 0, 0, 1'b0, 1, 'h100, 32'h0};
    vecs[2] = '{3, 5, 7, LAST, 0, 1'b0, 3, 5, 32'h0};
    vecs[3] = '{0, 0, 0, 0, 30, 1'b1, 0, 0, 32'h0};
    vecs[4] = '{3, 5, 7, LAST, 30, 1'b0, 3, 5, 32'h0};

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    // Abort at address 1000 and rescan from 0.
    clean = vecs[0];
    load_mem(clean);
`ifndef MEMVERIFY_STOP_ON_ERROR_EN
    mem[5] = 32'h0;
`endif
    next_addr   = 0;
    rden_cycles = 0;
    mon_en      = 1'b1;
    enable      = 1'b1;
    guard       = 0;
    while (guard < 5000) begin
      @(negedge clk);
      guard++;
      if (rden === 1'b1 && address == AW'(1000)) break;
    end
    chk("abort_reached_1000", 64'(address), 64'd1000);
`ifndef MEMVERIFY_STOP_ON_ERROR_EN
    chk("abort_pre_error_count", 64'(error_count), 64'd1);
`endif
    mon_en = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("abort");
    mem[5]      = pat(5);
    next_addr   = 0;
    rden_cycles = 0;
    mon_en      = 1'b1;
    enable      = 1'b1;
    @(posedge clk);
    wait_done(lat, to);
    chk("rescan_timeout", 64'(to), 64'd0);
    chk("rescan_pass", 64'(pass), 64'd1);
    chk("rescan_error_count", 64'(error_count), 64'd0);
    chk("rescan_rden_cycles", 64'(rden_cycles), 64'(LAST + 1));
    chk("rescan_latency", 64'(lat), 64'(LAST + RL + 2));
    $display("abort/rescan: lat=%0d pass=%0d errors=%0d reads=%0d", lat, pass, error_count, rden_cycles);
    mon_en = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
